// File: rtl/ntt_pkg.sv
// Shared NTT definitions: coefficient reader FSM states and address bit-reversal.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } coeff_rd_state_t;

  localparam int unsigned BITREV_MAX_W = 16;
  localparam int unsigned BITREV_IDX_W = $clog2(BITREV_MAX_W);

  // Reverses the low w bits of v; bits at and above w come back zero.
  function automatic logic [BITREV_MAX_W-1:0] bit_reverse(
    input logic [BITREV_MAX_W-1:0] v,
    input int unsigned             w
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[BITREV_IDX_W'(i)] = v[BITREV_IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/coeff_skid_fifo.sv
// Two-entry synchronous FIFO buffering RAM read data ahead of the output stream.
module coeff_skid_fifo #(
  parameter int unsigned DW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/coeff_ram_reader.sv
// Streams every coeff_ram word out on a valid/ready port, natural or bit-reversed order.
module coeff_ram_reader
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_rev,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last
);

  localparam int unsigned FW = WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  coeff_rd_state_t r_state, w_state_nxt;

  logic                  r_bit_rev;
  logic                  r_inflight;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_iss;
  logic [ADDR_WIDTH-1:0] r_inflight_idx;
  logic [ADDR_WIDTH-1:0] r_out_cnt;

  logic [1:0]            w_fifo_count;
  logic [FW-1:0]         w_fifo_head;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_last_pop;

  assign m_valid = (w_fifo_count != 2'd0);
  assign w_pop   = m_valid & m_ready;

  // Occupancy counts the read still in flight so two entries are never exceeded.
  assign w_issue = (r_state == RUN) &&
                   (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_last_issue = w_issue && (r_iss == LAST_IDX);
  assign w_last_pop   = w_pop && (r_out_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last_issue) w_state_nxt = DRAIN;
      DRAIN:   if (!r_inflight && w_last_pop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_rev      <= 1'b0;
      r_inflight     <= 1'b0;
      r_done         <= 1'b0;
      r_iss          <= '0;
      r_inflight_idx <= '0;
      r_out_cnt      <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_bit_rev <= bit_rev;
        r_iss     <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_issue) r_iss     <= r_iss + ADDR_WIDTH'(1);
        if (w_pop)   r_out_cnt <= r_out_cnt + ADDR_WIDTH'(1);
      end
      r_inflight     <= w_issue;
      r_inflight_idx <= r_iss;
      r_done         <= (r_state == DRAIN) && (w_state_nxt == IDLE);
    end
  end

  assign ram_addr = r_bit_rev ? ADDR_WIDTH'(bit_reverse(BITREV_MAX_W'(r_iss), ADDR_WIDTH))
                              : r_iss;

  coeff_skid_fifo #(
    .DW (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   ({r_inflight_idx, ram_dout}),
    .head  (w_fifo_head),
    .count (w_fifo_count)
  );

  assign m_data  = w_fifo_head[WIDTH-1:0];
  assign m_index = w_fifo_head[FW-1:WIDTH];
  assign m_last  = m_valid && (m_index == LAST_IDX);
  assign busy    = (r_state != IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_coeff_ram_reader.sv
// Scoreboard bench for coeff_ram_reader with a 16-word behavioural coeff_ram.
module tb_coeff_ram_reader;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, bit_rev, m_ready;
  logic          busy, done, m_valid, m_last;
  logic [AW-1:0] ram_addr, m_index;
  logic [W-1:0]  ram_dout, m_data;
  logic [W-1:0]  mem [D];

  typedef struct packed {
    logic [W-1:0]  data;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0, n_err = 0;
  int    cyc = 0, t0 = 0, beat_n = 0, done_cnt = 0, mode = 0;
  bit    active = 1'b0, cur_br = 1'b0, prev_stall = 1'b0;

  always #5 clk = ~clk;

  coeff_ram_reader #(
    .WIDTH      (W),
    .DEPTH      (D),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_rev  (bit_rev),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last)
  );

  always @(posedge clk) ram_dout <= mem[ram_addr];
  always @(posedge clk) cyc++;

  function automatic logic [AW-1:0] brev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    int    rel;
    beat_t e;
    rel = cyc - t0;
    if (active) begin
      if (prev_stall) check_val("valid_hold", 64'(m_valid), 64'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("m_data",  64'(m_data),  64'(e.data));
          check_val("m_index", 64'(m_index), 64'(e.idx));
          check_val("m_last",  64'(m_last),  64'(e.last));
        end
        if (mode == 0)      check_val("beat_cycle", 64'(rel), 64'(3 + beat_n));
        else if (mode == 2) check_val("beat_cycle", 64'(rel), 64'(21 + beat_n));
        beat_n++;
      end else if (m_valid && exp_q.size() > 0) begin
        check_val("stall_data",  64'(m_data),  64'(exp_q[0].data));
        check_val("stall_index", 64'(m_index), 64'(exp_q[0].idx));
      end
      prev_stall = m_valid && !m_ready;
      if (mode == 2 && rel >= 3 && rel <= 20) begin
        check_val("stall_addr",  64'(ram_addr), 64'd2);
        check_val("stall_valid", 64'(m_valid),  64'd1);
      end
      if (mode == 0 && rel <= int'(D) + 4) begin
        check_val("busy", 64'(busy), 64'(rel >= 1 && rel <= int'(D) + 2));
        if (rel >= 1 && rel <= int'(D))
          check_val("ram_addr", 64'(ram_addr),
                    64'(cur_br ? brev(AW'(rel - 1)) : AW'(rel - 1)));
      end
      if (done) begin
        done_cnt++;
        check_val("done_busy", 64'(busy), 64'd0);
        if (mode == 0) check_val("done_cycle", 64'(rel), 64'(D + 3));
      end
    end
  end

  // mode: 0 ready=1 with cycle timing, 1 random ready, 2 long stall, 3 ready=1 untimed
  task automatic run_case(input bit br, input int md, input int restart_rel, input bit do_rst);
    int          rel;
    int          settle;
    bit          rst_done;
    logic [AW-1:0] idx;
    settle   = 0;
    rst_done = 1'b0;
    exp_q.delete();
    for (int k = 0; k < D; k++) begin
      idx = AW'(k);
      exp_q.push_back('{data: mem[br ? brev(idx) : idx], idx: idx, last: (k == D - 1)});
    end
    beat_n     = 0;
    done_cnt   = 0;
    mode       = md;
    cur_br     = br;
    prev_stall = 1'b0;
    @(posedge clk); #2;
    start   = 1'b1;
    bit_rev = br;
    m_ready = 1'b1;
    t0      = cyc;
    active  = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #2;
      rel     = cyc - t0;
      start   = (rel == restart_rel);
      bit_rev = ~br;
      case (md)
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = !(rel >= 3 && rel <= 20);
        default: m_ready = 1'b1;
      endcase
      if (do_rst && !rst_done && beat_n >= 6) begin
        rst      = 1'b1;
        rst_done = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check_val("rst_busy",    64'(busy),     64'd0);
        check_val("rst_valid",   64'(m_valid),  64'd0);
        check_val("rst_done",    64'(done),     64'd0);
        check_val("rst_last",    64'(m_last),   64'd0);
        check_val("rst_addr",    64'(ram_addr), 64'd0);
      end
      if (done_cnt > 0 || rst_done) settle++;
      if (settle > 5) break;
    end
    if (do_rst) begin
      check_val("rst_no_done", 64'(done_cnt), 64'd0);
      check_val("rst_valid_after", 64'(m_valid), 64'd0);
    end else begin
      check_val("done_count", 64'(done_cnt), 64'd1);
      check_val("beat_count", 64'(beat_n), 64'(D));
      check_val("queue_left", 64'(exp_q.size()), 64'd0);
    end
    active = 1'b0;
    exp_q.delete();
    m_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'(100 + i);
    rst     = 1'b1;
    start   = 1'b0;
    bit_rev = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2;
    rst   = 1'b0;
    start = 1'b0;
    check_val("reset_busy",  64'(busy),     64'd0);
    check_val("reset_done",  64'(done),     64'd0);
    check_val("reset_valid", 64'(m_valid),  64'd0);
    check_val("reset_last",  64'(m_last),   64'd0);
    check_val("reset_data",  64'(m_data),   64'd0);
    check_val("reset_index", 64'(m_index),  64'd0);
    check_val("reset_addr",  64'(ram_addr), 64'd0);
    @(posedge clk); #2;
    check_val("start_in_rst_ignored", 64'(busy), 64'd0);

    run_case(1'b0, 0, -1, 1'b0);  // natural order
    run_case(1'b1, 0, -1, 1'b0);  // bit-reversed order
    run_case(1'b0, 1, -1, 1'b0);  // random backpressure
    run_case(1'b1, 1, -1, 1'b0);
    run_case(1'b0, 2, -1, 1'b0);  // long stall
    run_case(1'b0, 0,  8, 1'b0);  // start while busy
    run_case(1'b0, 3, -1, 1'b1);  // reset mid-stream
    run_case(1'b0, 0, -1, 1'b0);  // full stream after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coeff_ram_reader.md
# coeff_ram_reader

Streams a full polynomial out of `coeff_ram` after NTT computation completes. On `start`, the block walks all DEPTH addresses in natural or bit-reversed order on one RAM read port. It absorbs the RAM's 1-cycle read latency and presents coefficients on a valid/ready output stream with full backpressure support. It sits directly downstream of `coeff_ram` and drives that RAM port's address; the top level ties the port's write enable and write data to zero.

## Interface
- WIDTH, 32, coefficient width
- DEPTH, 256, coefficients per polynomial; must be a power of two
- ADDR_WIDTH, 8, log2(DEPTH)
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a readout; ignored while busy
- bit_rev  in  1  sampled with start; 1 selects bit-reversed RAM addressing
- busy  out  1  high from the cycle after an accepted start until the last beat is accepted
- done  out  1  one-cycle pulse in the cycle after the last handshake
- ram_addr  out  ADDR_WIDTH  read address to the coeff_ram port; driven from registered state
- ram_dout  in  WIDTH  coeff_ram read data; valid 1 cycle after its address is sampled
- m_valid  out  1  output beat valid
- m_ready  in  1  sink ready; handshake occurs when m_valid and m_ready are both high
- m_data  out  WIDTH  coefficient
- m_index  out  ADDR_WIDTH  stream position 0..DEPTH-1; this is the position, not the RAM address
- m_last  out  1  high on the beat with m_index = DEPTH-1

## Operation
- FSM states:
  - IDLE: start → RUN; bit_rev is latched and counters are cleared.
  - RUN: issues reads. After the DEPTH-th issue → DRAIN.
  - DRAIN: waits until the in-flight read has landed and the last beat is accepted → IDLE.
  - done pulses on the transition out of DRAIN.
- Issue counter `iss` runs 0..DEPTH-1.
  - ram_addr = iss when bit_rev is latched 0.
  - ram_addr = bit-reverse of iss over ADDR_WIDTH bits when bit_rev is latched 1.
- Output buffer is a 2-entry FIFO holding data and index.
  - A 1-bit `inflight` flag marks that ram_dout is meaningful in the current cycle.
  - When inflight is set, ram_dout is pushed into the FIFO at the end of that cycle.
- Issue rule in RUN: issue when fifo_count + inflight − pop < 2, where pop = m_valid & m_ready. This guarantees no FIFO overflow under any m_ready pattern.
- The out-counter increments on each pop. m_index, m_last, and m_data come from the FIFO head.
- The RAM port is never written by this block. RAM contents are not modified.
- start while busy is ignored. start in the same cycle as rst is ignored.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, m_valid = 0, m_last = 0
  - m_data = 0, m_index = 0, ram_addr = 0
  - FIFO empty, inflight = 0
- rst mid-operation: all state returns to reset values on the next edge. No further beats are emitted and done is not pulsed.
- Latency: start sampled in cycle 0 →
  - ram_addr holds the first address in cycle 1
  - ram_dout is valid in cycle 2
  - m_valid is first high in cycle 3
- Throughput: 1 beat per cycle while m_ready = 1.
  - With m_ready held at 1, beats occur in cycles 3..DEPTH+2.
  - busy is high in cycles 1..DEPTH+2.
  - done pulses in cycle DEPTH+3 with busy = 0.
- Backpressure: while m_ready = 0, m_data, m_index, and m_last hold stable and m_valid stays high. Issue stalls once the FIFO plus inflight reaches 2 entries.
- A new start is accepted in the done cycle, since the FSM is already in IDLE.

## Structure
- Shared package ntt_pkg holds:
  - the state typedef coeff_rd_state_t {IDLE, RUN, DRAIN}
  - a bit_reverse function parameterised by width, which the NTT address generators also use
- Sub-module coeff_skid_fifo implements the 2-entry, WIDTH+ADDR_WIDTH synchronous FIFO with push, pop, count, and head outputs. The top level holds the FSM, counters, and issue logic.
- A bench instantiates coeff_ram with DEPTH = 16 to keep runs short.

## Test plan
- Natural order: preload mem[i] = 100+i, DEPTH = 16, bit_rev = 0, m_ready = 1. Expect:
  - m_data = 100..115 in cycles 3..18
  - m_index = 0..15, with m_last only at index 15
  - done in cycle 19
- Bit-reversed order: same preload, bit_rev = 1. Expect m_data sequence 100, 108, 104, 112, 102, … (mem[bitrev4(k)]) with m_index = 0..15.
- Random backpressure: m_ready follows a 50% random pattern. Expect:
  - all 16 values in order, with no duplicates or drops
  - outputs stable while stalled
  - done exactly once
- Long stall: m_ready = 0 for cycles 3..20, then 1. Expect:
  - m_data = 100 held from cycle 3
  - ram_addr frozen after 2 outstanding reads
  - the remaining 15 beats back to back after release
- start while busy: pulse start at cycle 8. Expect it to be ignored, with a single 16-beat stream and one done pulse.
- Reset mid-stream: assert rst for 1 cycle after beat 5. Expect:
  - m_valid = 0, busy = 0, done never pulsed
  - a subsequent start produces a full stream beginning at m_index = 0
